food_arbiter: RTL and testbench
===============================

FOOD_ARBITER -- requirements
Module: food_arbiter

Interface
REQ-001 SHALL have parameter COLS, default 96, food-grid columns.
REQ-002 SHALL have parameter ROWS, default 72, food-grid rows.
REQ-003 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port start_level  in  1  one-cycle pulse; (re)load grid from ROM.
REQ-006 SHALL have port vga_req  in  1  pixel-path read request, sampled every cycle.
REQ-007 SHALL have port vga_cx  in  7  pixel-path cell column.
REQ-008 SHALL have port vga_cy  in  7  pixel-path cell row.
REQ-009 SHALL have port vga_valid  out  1  read result valid, 2 cycles after granted vga_req.
REQ-010 SHALL have port vga_food  out  1  food-present bit for that read; 0 when vga_valid low.
REQ-011 SHALL have port eat_req  in  1  Pacman eat request, held high until eat_ack.
REQ-012 SHALL have port eat_cx  in  7  Pacman cell column, stable while eat_req high.
REQ-013 SHALL have port eat_cy  in  7  Pacman cell row, stable while eat_req high.
REQ-014 SHALL have port eat_ack  out  1  one-cycle completion pulse.
REQ-015 SHALL have port eat_hit  out  1  valid with eat_ack; 1 = food was present and removed.
REQ-016 SHALL have port mem_addr  out  13  single-port food RAM address, cy*COLS+cx.
REQ-017 SHALL have port mem_we  out  1  RAM write enable.
REQ-018 SHALL have port mem_wdata  out  1  RAM write data.
REQ-019 SHALL have port mem_rdata  in  1  RAM read data, 1-cycle latency.
REQ-020 SHALL have port rom_addr  out  13  initial-pattern ROM address.
REQ-021 SHALL have port rom_data  in  1  ROM data, 1-cycle latency.
REQ-022 SHALL have port food_count  out  13  pellets remaining.
REQ-023 SHALL have port gamewin  out  1  registered; 1 when level loaded and food_count==0.

Function
REQ-024 SHALL implement FSM states IDLE, INIT, RUN, EAT_RD, EAT_WR; at most one RAM access per cycle.
REQ-025 IDLE: no RAM access; start_level -> INIT.
REQ-026 INIT: rom_addr steps 0..COLS*ROWS-1, one per cycle; cycle k+1 writes rom_data to mem_addr k and increments food_count if 1; after COLS*ROWS+1 cycles set loaded, go to RUN.
REQ-027 INIT clears food_count to 0 on entry; any grant to vga_req during INIT returns vga_valid=1, vga_food=0 with no RAM access.
REQ-028 RUN: vga_req granted by default (read, mem_we=0); eat_req granted only when vga_req low, except per REQ-038.
REQ-029 Granted eat -> EAT_RD (read addr); EAT_WR: if mem_rdata=1 write 0, decrement food_count, eat_hit=1; else no write, eat_hit=0; eat_ack pulses in EAT_WR; return to RUN.
REQ-030 vga_req arriving during EAT_RD/EAT_WR SHALL not be granted: vga_valid=0 in its result slot.
REQ-031 Out-of-range coordinates (cx>=COLS or cy>=ROWS): vga -> valid with food=0; eat -> eat_ack, eat_hit=0 one cycle later; no RAM access.
REQ-032 start_level in any state SHALL restart INIT at address 0 next cycle; in-flight eat is dropped with no ack and no decrement (held eat_req is served after INIT).
REQ-033 food_count SHALL never wrap below 0.
REQ-034 gamewin SHALL update one cycle after food_count reaches 0; held 0 during INIT.

Reset
REQ-035 reset SHALL force IDLE, loaded=0, food_count=0, gamewin=0, vga_valid=0, vga_food=0, eat_ack=0, eat_hit=0, mem_we=0, mem_addr=0, rom_addr=0.
REQ-036 reset SHALL dominate start_level in the same cycle.

Configuration
REQ-037 Macro FOOD_AGING_EN SHALL select eat starvation protection.
REQ-038 With FOOD_AGING_EN: 4-bit wait counter counts cycles eat_req is pending in RUN; at 15, eat granted over vga_req; counter clears on grant. Without: strict VGA priority, eat may wait indefinitely.

Verification
REQ-039 ROM pattern with 3 ones at addresses 0,5,6911, start_level -> food_count=3 after 6913 cycles, gamewin=0.
REQ-040 vga_req at cell (5,0) in RUN -> mem_addr=5, vga_valid=1 and vga_food=1 two cycles later.
REQ-041 eat_req at (5,0), vga_req low -> eat_ack with eat_hit=1, food_count 3->2, mem_we=1 with wdata 0; repeat -> eat_hit=0, count unchanged.
REQ-042 Eat cells 0,5,6911 -> food_count=0, gamewin=1 next cycle; start_level -> gamewin=0 during INIT.
REQ-043 vga_req held high, eat_req pending -> with FOOD_AGING_EN eat_ack within 17 cycles; without, no eat_ack.
REQ-044 start_level asserted in EAT_RD -> no eat_ack, INIT restarts at rom_addr 0, food_count reloaded to 3.

Source files
------------

// File: rtl/food_arbiter.sv
// rtl/food_arbiter.sv - arbitrates the food-grid RAM between VGA reads, Pacman eats and ROM level load
// Optional macro FOOD_AGING_EN: eat starvation protection via a 4-bit wait counter.
module food_arbiter #(
   parameter int COLS = 96,
   parameter int ROWS = 72
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start_level,
   input  logic        vga_req,
   input  logic [6:0]  vga_cx,
   input  logic [6:0]  vga_cy,
   output logic        vga_valid,
   output logic        vga_food,
   input  logic        eat_req,
   input  logic [6:0]  eat_cx,
   input  logic [6:0]  eat_cy,
   output logic        eat_ack,
   output logic        eat_hit,
   output logic [12:0] mem_addr,
   output logic        mem_we,
   output logic        mem_wdata,
   input  logic        mem_rdata,
   output logic [12:0] rom_addr,
   input  logic        rom_data,
   output logic [12:0] food_count,
   output logic        gamewin
);

   localparam logic [7:0]  W_COLS = 8'(COLS);
   localparam logic [7:0]  W_ROWS = 8'(ROWS);
   localparam logic [12:0] CELLS  = 13'(COLS * ROWS);

   typedef enum logic [2:0] {IDLE, INIT, RUN, EAT_RD, EAT_WR} state_t;
   state_t r_state;

   logic [12:0] r_mem_addr, r_rom_addr, r_count, r_init_cnt;
   logic        r_mem_we, r_loaded, r_gamewin, r_eat_ack, r_eat_hit;
   logic        r_p1_valid, r_p1_ram, r_vga_valid, r_p2_ram;

   logic        w_vga_in, w_eat_in, w_eat_pend, w_eat_first, w_init_wr;
   logic [12:0] w_vga_addr, w_eat_addr;

   assign w_vga_in   = ({1'b0, vga_cx} < W_COLS) && ({1'b0, vga_cy} < W_ROWS);
   assign w_eat_in   = ({1'b0, eat_cx} < W_COLS) && ({1'b0, eat_cy} < W_ROWS);
   assign w_vga_addr = 13'(vga_cy) * 13'(COLS) + 13'(vga_cx);
   assign w_eat_addr = 13'(eat_cy) * 13'(COLS) + 13'(eat_cx);
   // the ack cycle still sees eat_req high, so it must not count as a new request
   assign w_eat_pend = eat_req && !r_eat_ack;
   assign w_init_wr  = (r_state == INIT) && r_mem_we;

`ifdef FOOD_AGING_EN
   logic [3:0] r_wait;

   // the fifteenth consecutive pending cycle takes the slot from the pixel path
   assign w_eat_first = w_eat_pend && (r_wait == 4'd14);

   always_ff @(posedge clk) begin
      if (reset || start_level || r_state != RUN || !w_eat_pend || !vga_req || w_eat_first)
         r_wait <= 4'd0;
      else if (r_wait != 4'd15)
         r_wait <= r_wait + 4'd1;
   end
`else
   assign w_eat_first = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= IDLE;
         r_loaded    <= 1'b0;
         r_count     <= 13'd0;
         r_gamewin   <= 1'b0;
         r_vga_valid <= 1'b0;
         r_p1_valid  <= 1'b0;
         r_p1_ram    <= 1'b0;
         r_p2_ram    <= 1'b0;
         r_eat_ack   <= 1'b0;
         r_eat_hit   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= 13'd0;
         r_rom_addr  <= 13'd0;
         r_init_cnt  <= 13'd0;
      end else begin
         r_eat_ack   <= 1'b0;
         r_eat_hit   <= 1'b0;
         r_p1_valid  <= 1'b0;
         r_p1_ram    <= 1'b0;
         r_vga_valid <= r_p1_valid;
         r_p2_ram    <= r_p1_ram;
         r_gamewin   <= r_loaded && (r_count == 13'd0);
         if (start_level) begin
            r_state    <= INIT;
            r_loaded   <= 1'b0;
            r_count    <= 13'd0;
            r_gamewin  <= 1'b0;
            r_mem_we   <= 1'b0;
            r_rom_addr <= 13'd0;
            r_init_cnt <= 13'd0;
         end else begin
            case (r_state)
               IDLE: r_mem_we <= 1'b0;
               INIT: begin
                  if (vga_req)
                     r_p1_valid <= 1'b1;
                  if (r_mem_we && rom_data)
                     r_count <= r_count + 13'd1;
                  // cell k is written one cycle after its ROM address, hence CELLS+1 cycles
                  if (r_init_cnt == CELLS) begin
                     r_state  <= RUN;
                     r_loaded <= 1'b1;
                     r_mem_we <= 1'b0;
                  end else begin
                     r_mem_we   <= 1'b1;
                     r_mem_addr <= r_init_cnt;
                     r_init_cnt <= r_init_cnt + 13'd1;
                     if (r_init_cnt + 13'd1 < CELLS)
                        r_rom_addr <= r_init_cnt + 13'd1;
                  end
               end
               RUN: begin
                  r_mem_we <= 1'b0;
                  if (vga_req && !w_eat_first) begin
                     r_p1_valid <= 1'b1;
                     r_p1_ram   <= w_vga_in;
                     if (w_vga_in)
                        r_mem_addr <= w_vga_addr;
                  end else if (w_eat_pend) begin
                     if (w_eat_in) begin
                        r_state    <= EAT_RD;
                        r_mem_addr <= w_eat_addr;
                     end else begin
                        r_eat_ack <= 1'b1;
                     end
                  end
               end
               EAT_RD: begin
                  r_mem_we <= 1'b0;
                  r_state  <= EAT_WR;
               end
               EAT_WR: begin
                  r_eat_ack <= 1'b1;
                  r_eat_hit <= mem_rdata;
                  r_mem_we  <= mem_rdata;
                  if (mem_rdata && r_count != 13'd0)
                     r_count <= r_count - 13'd1;
                  r_state <= RUN;
               end
               default: r_state <= IDLE;
            endcase
         end
      end
   end

   assign vga_valid  = r_vga_valid;
   assign vga_food   = r_vga_valid & r_p2_ram & mem_rdata;
   assign eat_ack    = r_eat_ack;
   assign eat_hit    = r_eat_hit;
   assign mem_addr   = r_mem_addr;
   assign mem_we     = r_mem_we;
   assign mem_wdata  = w_init_wr & rom_data;
   assign rom_addr   = r_rom_addr;
   assign food_count = r_count;
   assign gamewin    = r_gamewin;

endmodule

// File: tb/tb_food_arbiter.sv
// tb/tb_food_arbiter.sv - self-checking bench for food_arbiter with RAM/ROM models and a VGA scoreboard
module tb_food_arbiter;

   localparam int COLS = 96;
   localparam int ROWS = 72;
   localparam int N    = COLS * ROWS;

   logic        clk = 1'b0;
   logic        reset, start_level;
   logic        vga_req, eat_req;
   logic [6:0]  vga_cx, vga_cy, eat_cx, eat_cy;
   logic        vga_valid, vga_food, eat_ack, eat_hit;
   logic [12:0] mem_addr, rom_addr, food_count;
   logic        mem_we, mem_wdata, mem_rdata, rom_data, gamewin;

   logic ram [0:8191];

   food_arbiter #(.COLS(COLS), .ROWS(ROWS)) dut (
      .clk(clk), .reset(reset), .start_level(start_level),
      .vga_req(vga_req), .vga_cx(vga_cx), .vga_cy(vga_cy),
      .vga_valid(vga_valid), .vga_food(vga_food),
      .eat_req(eat_req), .eat_cx(eat_cx), .eat_cy(eat_cy),
      .eat_ack(eat_ack), .eat_hit(eat_hit),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .rom_addr(rom_addr), .rom_data(rom_data),
      .food_count(food_count), .gamewin(gamewin)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // single-port RAM and pattern ROM, both with one-cycle read latency
   always @(posedge clk) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
      rom_data  <= (rom_addr == 13'd0) || (rom_addr == 13'd5) || (rom_addr == 13'd6911);
   end

   int n_tests = 0;
   int n_fail  = 0;
   bit loose   = 1'b0;

   typedef struct {int cyc; logic valid; logic food;} vexp_t;
   vexp_t vq[$];
   vexp_t mon_e;

   typedef struct {bit is_eat; int cx; int cy; bit exp; int cnt;} vec_t;
   vec_t vecs[12];

   task automatic chk(input string nm, input int got, input int exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, got, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_n(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // each granted pixel read must come back exactly two cycles after it was issued
   initial begin
      forever begin
         @(posedge clk);
         #2;
         if (vq.size() > 0 && vq[0].cyc + 2 <= cyc) begin
            mon_e = vq.pop_front();
            chk("vga_valid", int'(vga_valid), int'(mon_e.valid));
            chk("vga_food", int'(vga_food), int'(mon_e.food));
         end else if (vga_valid) begin
            if (loose) chk("vga_food_loose", int'(vga_food), 0);
            else       chk("vga_unexpected_valid", int'(vga_valid), 0);
         end else if (vga_food) begin
            chk("vga_food_without_valid", int'(vga_food), 0);
         end
      end
   end

   task automatic do_vga(input int cx, input int cy, input bit exp_food);
      bit inr;
      inr = (cx < COLS) && (cy < ROWS);
      vga_cx  = 7'(cx);
      vga_cy  = 7'(cy);
      vga_req = 1'b1;
      vq.push_back('{cyc, 1'b1, logic'(exp_food)});
      tick();
      vga_req = 1'b0;
      if (inr) chk("vga_mem_addr", int'(mem_addr), cy * COLS + cx);
      chk("vga_no_write", int'(mem_we), 0);
      wait_n(2);
   endtask

   task automatic do_eat(input int cx, input int cy, input bit exp_hit, input int exp_cnt);
      bit got;
      got     = 1'b0;
      eat_cx  = 7'(cx);
      eat_cy  = 7'(cy);
      eat_req = 1'b1;
      for (int i = 0; i < 20 && !got; i++) begin
         tick();
         if (eat_ack) got = 1'b1;
      end
      chk("eat_ack_seen", int'(got), 1);
      if (got) begin
         chk("eat_hit", int'(eat_hit), int'(exp_hit));
         chk("eat_count", int'(food_count), exp_cnt);
         chk("eat_mem_we", int'(mem_we), int'(exp_hit));
         if (exp_hit) begin
            chk("eat_wdata", int'(mem_wdata), 0);
            chk("eat_waddr", int'(mem_addr), cy * COLS + cx);
         end
      end
      eat_req = 1'b0;
   endtask

   initial begin
      int n_ack;
      bit got;
      vecs[0]  = '{1'b0,  5,  0, 1'b1, 3};
      vecs[1]  = '{1'b0,  1,  0, 1'b0, 3};
      vecs[2]  = '{1'b0, 95, 71, 1'b1, 3};
      vecs[3]  = '{1'b0, 96,  0, 1'b0, 3};
      vecs[4]  = '{1'b0,  0, 72, 1'b0, 3};
      vecs[5]  = '{1'b0,  0,  0, 1'b1, 3};
      vecs[6]  = '{1'b1,  5,  0, 1'b1, 2};
      vecs[7]  = '{1'b1,  5,  0, 1'b0, 2};
      vecs[8]  = '{1'b0,  5,  0, 1'b0, 2};
      vecs[9]  = '{1'b1, 100, 3, 1'b0, 2};
      vecs[10] = '{1'b1,  0,  0, 1'b1, 1};
      vecs[11] = '{1'b1, 95, 71, 1'b1, 0};

      // reset held together with start_level: reset must win
      reset = 1'b1; start_level = 1'b1;
      vga_req = 1'b0; eat_req = 1'b0;
      vga_cx = 7'd0; vga_cy = 7'd0; eat_cx = 7'd0; eat_cy = 7'd0;
      wait_n(2);
      chk("rst_vga_valid", int'(vga_valid), 0);
      chk("rst_eat_ack", int'(eat_ack), 0);
      chk("rst_eat_hit", int'(eat_hit), 0);
      chk("rst_mem_we", int'(mem_we), 0);
      chk("rst_mem_addr", int'(mem_addr), 0);
      chk("rst_rom_addr", int'(rom_addr), 0);
      chk("rst_food_count", int'(food_count), 0);
      chk("rst_gamewin", int'(gamewin), 0);
      reset = 1'b0; start_level = 1'b0;
      vga_cx = 7'd5; vga_req = 1'b1;
      vq.push_back('{cyc, 1'b0, 1'b0});
      tick();
      vga_req = 1'b0;
      tick();
      chk("idle_mem_we", int'(mem_we), 0);
      chk("idle_rom_addr", int'(rom_addr), 0);
      wait_n(2);

      // level load
      start_level = 1'b1;
      tick();
      start_level = 1'b0;
      chk("init0_rom_addr", int'(rom_addr), 0);
      chk("init0_mem_we", int'(mem_we), 0);
      vga_cx = 7'd5; vga_cy = 7'd0; vga_req = 1'b1;
      vq.push_back('{cyc, 1'b1, 1'b0});
      tick();
      vga_req = 1'b0;
      chk("init1_rom_addr", int'(rom_addr), 1);
      chk("init1_mem_we", int'(mem_we), 1);
      chk("init1_mem_addr", int'(mem_addr), 0);
      wait_n(N - 1);
      chk("init_last_count", int'(food_count), 2);
      tick();
      chk("load_count", int'(food_count), 3);
      chk("load_gamewin", int'(gamewin), 0);

      for (int i = 0; i < 12; i++) begin
         if (vecs[i].is_eat) do_eat(vecs[i].cx, vecs[i].cy, vecs[i].exp, vecs[i].cnt);
         else                do_vga(vecs[i].cx, vecs[i].cy, vecs[i].exp);
      end
      chk("gamewin_lag", int'(gamewin), 0);
      tick();
      chk("gamewin_set", int'(gamewin), 1);
      wait_n(2);

      // reload: gamewin must drop immediately and stay low through INIT
      start_level = 1'b1;
      tick();
      start_level = 1'b0;
      chk("reload_gamewin", int'(gamewin), 0);
      chk("reload_count_clr", int'(food_count), 0);
      wait_n(N);
      tick();
      chk("reload_count", int'(food_count), 3);
      chk("reload_gamewin_end", int'(gamewin), 0);

      // pixel path hogging the RAM while an eat waits
      loose   = 1'b1;
      vga_cx  = 7'd1; vga_cy = 7'd0; vga_req = 1'b1;
      eat_cx  = 7'd5; eat_cy = 7'd0; eat_req = 1'b1;
      got     = 1'b0;
`ifdef FOOD_AGING_EN
      for (int i = 0; i < 17 && !got; i++) begin
         tick();
         if (eat_ack) begin
            got = 1'b1;
            chk("aging_hit", int'(eat_hit), 1);
            chk("aging_count", int'(food_count), 2);
         end
      end
      chk("aging_ack_in_17", int'(got), 1);
      eat_req = 1'b0;
      vga_req = 1'b0;
`else
      n_ack = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (eat_ack) n_ack++;
      end
      chk("strict_no_ack", n_ack, 0);
      vga_req = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
         tick();
         if (eat_ack) begin
            got = 1'b1;
            chk("strict_late_hit", int'(eat_hit), 1);
            chk("strict_late_count", int'(food_count), 2);
         end
      end
      chk("strict_late_ack", int'(got), 1);
      eat_req = 1'b0;
`endif
      wait_n(4);
      loose = 1'b0;

      // start_level while the eat is in its read cycle
      eat_cx = 7'd0; eat_cy = 7'd0; eat_req = 1'b1;
      tick();
      start_level = 1'b1;
      tick();
      start_level = 1'b0;
      chk("drop_rom_addr", int'(rom_addr), 0);
      chk("drop_mem_we", int'(mem_we), 0);
      chk("drop_eat_ack", int'(eat_ack), 0);
      chk("drop_count_clr", int'(food_count), 0);
      n_ack = 0;
      for (int i = 0; i < N; i++) begin
         tick();
         if (eat_ack) n_ack++;
      end
      tick();
      chk("drop_no_ack_in_init", n_ack, 0);
      chk("drop_reload_count", int'(food_count), 3);
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
         tick();
         if (eat_ack) begin
            got = 1'b1;
            chk("held_eat_hit", int'(eat_hit), 1);
            chk("held_eat_count", int'(food_count), 2);
         end
      end
      chk("held_eat_ack", int'(got), 1);
      eat_req = 1'b0;
      wait_n(4);
      chk("vga_queue_drained", vq.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
